// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// datapath mux selects and the bundled control-word struct.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_IMMEX  = 4'd9,
      S_IMMWB  = 4'd10,
      S_JUMP   = 4'd11,
      S_JALST  = 4'd12
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_FUNCT = 3'b010;
   localparam logic [2:0] ALUOP_AND   = 3'b011;
   localparam logic [2:0] ALUOP_OR    = 3'b100;
   localparam logic [2:0] ALUOP_SLT   = 3'b101;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_DATA   = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;

   localparam logic [1:0] RDST_RT = 2'b00;
   localparam logic [1:0] RDST_RD = 2'b01;
   localparam logic [1:0] RDST_RA = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       i_or_d;
      logic       ir_write;
      logic       reg_write;
      logic       mem_write;
      logic       branch;
      logic       branch_ne;
      logic       pc_write;
      logic [1:0] pc_src;
      logic [1:0] mem_to_reg;
      logic [1:0] reg_dst;
      logic [2:0] alu_op;
      logic       illegal_op;
      logic       mem_timeout;
   } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_v2_watchdog.sv
// Stall counter for memory states: pulses timeout on the last allowed
// not-ready cycle; a ready in that same cycle suppresses the abort.
module mc_stall_watchdog #(
   parameter int unsigned TIMEOUT_W      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 12
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic rdy,
   output logic timeout
);

   localparam logic [TIMEOUT_W-1:0] LAST =
      TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      timeout = (TIMEOUT_CYCLES != 0) && active && !rdy && (cnt_q == LAST);
      cnt_d   = '0;
      if (active && !rdy && !timeout)
         cnt_d = cnt_q + TIMEOUT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/multicycle_ctrl_fsm_v2.sv
// Main control FSM for the multicycle MIPS datapath with memory handshake,
// stall watchdog and illegal-opcode flag.
module multicycle_ctrl_fsm_v2
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned MEM_HANDSHAKE  = 1,
   parameter int unsigned TIMEOUT_W      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 12
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] OpCode,
   input  logic       MemReady,
   output logic       MemReq,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       IorD,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       Branch,
   output logic       BranchNe,
   output logic       PCWrite,
   output logic [1:0] PCSrc,
   output logic [1:0] MemToReg,
   output logic [1:0] RegDst,
   output logic [2:0] ALUOp,
   output logic       IllegalOp,
   output logic       MemTimeout
);

   localparam logic WD_EN = (MEM_HANDSHAKE != 0) && (TIMEOUT_CYCLES != 0);

   state_t state_q, state_d;
   ctrl_t  ctrl, ctrl_o;
   logic   rdy, wd_active, timeout;

   assign rdy       = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;
   assign wd_active = WD_EN && (state_q inside {S_FETCH, S_MEMRD, S_MEMWR});

   mc_stall_watchdog #(
      .TIMEOUT_W      (TIMEOUT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (CLK),
      .rst     (RST),
      .active  (wd_active),
      .rdy     (rdy),
      .timeout (timeout)
   );

   always_comb begin
      ctrl    = '0;
      state_d = S_FETCH;
      unique case (state_q)
         S_FETCH: begin
            ctrl.mem_req   = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.ir_write  = rdy;
            ctrl.pc_write  = rdy;
            state_d        = rdy ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMMSH;
            case (OpCode)
               OP_LW, OP_SW:                       state_d = S_MEMADR;
               OP_R:                               state_d = S_EXEC;
               OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  state_d = S_IMMEX;
               OP_J:                               state_d = S_JUMP;
               OP_JAL:                             state_d = S_JALST;
               default: begin
                  ctrl.illegal_op = 1'b1;
                  state_d         = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            state_d        = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            ctrl.mem_req = 1'b1;
            ctrl.i_or_d  = 1'b1;
            state_d      = rdy ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = M2R_DATA;
            ctrl.reg_dst    = RDST_RT;
         end
         S_MEMWR: begin
            ctrl.mem_req   = 1'b1;
            ctrl.i_or_d    = 1'b1;
            ctrl.mem_write = 1'b1;
            state_d        = rdy ? S_FETCH : S_MEMWR;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALUOP_FUNCT;
            state_d        = S_ALUWB;
         end
         S_ALUWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = RDST_RD;
            ctrl.mem_to_reg = M2R_ALUOUT;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALUOP_SUB;
            ctrl.pc_src    = PCSRC_ALUOUT;
            ctrl.branch    = (OpCode == OP_BEQ);
            ctrl.branch_ne = (OpCode == OP_BNE);
         end
         S_IMMEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            case (OpCode)
               OP_SLTI: ctrl.alu_op = ALUOP_SLT;
               OP_ANDI: ctrl.alu_op = ALUOP_AND;
               OP_ORI:  ctrl.alu_op = ALUOP_OR;
               default: ctrl.alu_op = ALUOP_ADD;
            endcase
            state_d = S_IMMWB;
         end
         S_IMMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = RDST_RT;
            ctrl.mem_to_reg = M2R_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_src   = PCSRC_JUMP;
            ctrl.pc_write = 1'b1;
         end
         S_JALST: begin
            ctrl.pc_src     = PCSRC_JUMP;
            ctrl.pc_write   = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = RDST_RA;
            ctrl.mem_to_reg = M2R_PC;
         end
         default: state_d = S_FETCH;
      endcase

      // An abort overrides whatever the memory state decoded: no writes, refetch.
      if (timeout) begin
         ctrl.mem_timeout = 1'b1;
         ctrl.ir_write    = 1'b0;
         ctrl.pc_write    = 1'b0;
         ctrl.mem_write   = 1'b0;
         ctrl.reg_write   = 1'b0;
         state_d          = S_FETCH;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   assign ctrl_o     = RST ? '0 : ctrl;
   assign MemReq     = ctrl_o.mem_req;
   assign ALUSrcA    = ctrl_o.alu_src_a;
   assign ALUSrcB    = ctrl_o.alu_src_b;
   assign IorD       = ctrl_o.i_or_d;
   assign IRWrite    = ctrl_o.ir_write;
   assign RegWrite   = ctrl_o.reg_write;
   assign MemWrite   = ctrl_o.mem_write;
   assign Branch     = ctrl_o.branch;
   assign BranchNe   = ctrl_o.branch_ne;
   assign PCWrite    = ctrl_o.pc_write;
   assign PCSrc      = ctrl_o.pc_src;
   assign MemToReg   = ctrl_o.mem_to_reg;
   assign RegDst     = ctrl_o.reg_dst;
   assign ALUOp      = ctrl_o.alu_op;
   assign IllegalOp  = ctrl_o.illegal_op;
   assign MemTimeout = ctrl_o.mem_timeout;

endmodule

// File: tb/tb_multicycle_ctrl_fsm_v2.sv
// Directed-vector bench for multicycle_ctrl_fsm_v2: each cycle's full
// control word is compared against a hand-built expected word.
module tb_multicycle_ctrl_fsm_v2;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       mem_req, alu_src_a, i_or_d, ir_write, reg_write, mem_write;
   logic       branch, branch_ne, pc_write, illegal_op, mem_timeout;
   logic [1:0] alu_src_b, pc_src, mem_to_reg, reg_dst;
   logic [2:0] alu_op;
   logic [21:0] obs;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   multicycle_ctrl_fsm_v2 #(
      .MEM_HANDSHAKE  (1),
      .TIMEOUT_W      (4),
      .TIMEOUT_CYCLES (12)
   ) dut (
      .CLK        (clk),
      .RST        (rst),
      .OpCode     (opcode),
      .MemReady   (mem_ready),
      .MemReq     (mem_req),
      .ALUSrcA    (alu_src_a),
      .ALUSrcB    (alu_src_b),
      .IorD       (i_or_d),
      .IRWrite    (ir_write),
      .RegWrite   (reg_write),
      .MemWrite   (mem_write),
      .Branch     (branch),
      .BranchNe   (branch_ne),
      .PCWrite    (pc_write),
      .PCSrc      (pc_src),
      .MemToReg   (mem_to_reg),
      .RegDst     (reg_dst),
      .ALUOp      (alu_op),
      .IllegalOp  (illegal_op),
      .MemTimeout (mem_timeout)
   );

   always #5 clk = ~clk;

   assign obs = {mem_req, alu_src_a, alu_src_b, i_or_d, ir_write, reg_write,
                 mem_write, branch, branch_ne, pc_write, pc_src, mem_to_reg,
                 reg_dst, alu_op, illegal_op, mem_timeout};

   function automatic logic [21:0] mk(
      input logic mreq, srca, input logic [1:0] srcb, input logic iord, irw,
      rw, mw, br, bne, pcw, input logic [1:0] pcs, m2r, rdst,
      input logic [2:0] aop, input logic ill, to);
      return {mreq, srca, srcb, iord, irw, rw, mw, br, bne, pcw, pcs, m2r,
              rdst, aop, ill, to};
   endfunction

   // Expected control words per state, built field by field from the state table.
   localparam logic [21:0] ZERO      = 22'd0;
   logic [21:0] E_FETCH_RDY, E_FETCH_WAIT, E_DECODE, E_ILLEGAL, E_MEMADR,
                E_MEMRD, E_MEMWB, E_MEMWR, E_MEMWR_TO, E_EXEC, E_ALUWB,
                E_BEQ, E_BNE, E_IMMEX_OR, E_IMMWB, E_JALST;

   task automatic check(input string tag, input logic [21:0] got,
                        input logic [21:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Settle, compare, then advance one clock and sit 1 unit past the edge.
   task automatic step(input string tag, input logic [21:0] exp);
      #1;
      check(tag, obs, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      E_FETCH_RDY  = mk(1,0,2'b01,0,1,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,0,0);
      E_FETCH_WAIT = mk(1,0,2'b01,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0);
      E_DECODE     = mk(0,0,2'b11,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0);
      E_ILLEGAL    = mk(0,0,2'b11,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,1,0);
      E_MEMADR     = mk(0,1,2'b10,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0);
      E_MEMRD      = mk(1,0,2'b00,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0);
      E_MEMWB      = mk(0,0,2'b00,0,0,1,0,0,0,0,2'b00,2'b01,2'b00,3'b000,0,0);
      E_MEMWR      = mk(1,0,2'b00,1,0,0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0);
      E_MEMWR_TO   = mk(1,0,2'b00,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,1);
      E_EXEC       = mk(0,1,2'b00,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b010,0,0);
      E_ALUWB      = mk(0,0,2'b00,0,0,1,0,0,0,0,2'b00,2'b00,2'b01,3'b000,0,0);
      E_BEQ        = mk(0,1,2'b00,0,0,0,0,1,0,0,2'b01,2'b00,2'b00,3'b001,0,0);
      E_BNE        = mk(0,1,2'b00,0,0,0,0,0,1,0,2'b01,2'b00,2'b00,3'b001,0,0);
      E_IMMEX_OR   = mk(0,1,2'b10,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b100,0,0);
      E_IMMWB      = mk(0,0,2'b00,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0);
      E_JALST      = mk(0,0,2'b00,0,0,1,0,0,0,1,2'b10,2'b10,2'b10,3'b000,0,0);

      rst = 1'b1; mem_ready = 1'b1; opcode = 6'b100011;
      step("rst_c0", ZERO);
      step("rst_c1", ZERO);
      rst = 1'b0;

      // LW with memory always ready
      step("lw_fetch",  E_FETCH_RDY);
      step("lw_decode", E_DECODE);
      step("lw_memadr", E_MEMADR);
      step("lw_memrd",  E_MEMRD);
      step("lw_memwb",  E_MEMWB);

      // Fetch stalled 3 cycles, then SW that never completes -> watchdog abort
      mem_ready = 1'b0; opcode = 6'b101011;
      for (int i = 0; i < 3; i++) step("fetch_wait", E_FETCH_WAIT);
      mem_ready = 1'b1;
      step("fetch_go",  E_FETCH_RDY);
      step("sw_decode", E_DECODE);
      step("sw_memadr", E_MEMADR);
      mem_ready = 1'b0;
      for (int i = 0; i < 11; i++) step("sw_stall", E_MEMWR);
      step("sw_timeout", E_MEMWR_TO);
      mem_ready = 1'b1;
      step("after_to_fetch", E_FETCH_RDY);

      // SW with ready arriving exactly on the would-be timeout cycle
      step("sw2_decode", E_DECODE);
      step("sw2_memadr", E_MEMADR);
      mem_ready = 1'b0;
      for (int i = 0; i < 11; i++) step("sw2_stall", E_MEMWR);
      mem_ready = 1'b1;
      step("sw2_late_rdy", E_MEMWR);
      step("sw2_fetch", E_FETCH_RDY);

      // JAL
      opcode = 6'b000011;
      step("jal_decode", E_DECODE);
      step("jal_jalst",  E_JALST);
      step("jal_fetch",  E_FETCH_RDY);
      // BNE
      opcode = 6'b000101;
      step("bne_decode", E_DECODE);
      step("bne_branch", E_BNE);
      step("bne_fetch",  E_FETCH_RDY);
      // BEQ
      opcode = 6'b000100;
      step("beq_decode", E_DECODE);
      step("beq_branch", E_BEQ);
      step("beq_fetch",  E_FETCH_RDY);
      // ORI
      opcode = 6'b001101;
      step("ori_decode", E_DECODE);
      step("ori_immex",  E_IMMEX_OR);
      step("ori_immwb",  E_IMMWB);
      step("ori_fetch",  E_FETCH_RDY);
      // R-type
      opcode = 6'b000000;
      step("r_decode", E_DECODE);
      step("r_exec",   E_EXEC);
      step("r_aluwb",  E_ALUWB);
      step("r_fetch",  E_FETCH_RDY);
      // Illegal opcode
      opcode = 6'b111111;
      step("ill_decode", E_ILLEGAL);
      step("ill_fetch",  E_FETCH_RDY);

      // Reset in the middle of a stalled SW
      opcode = 6'b101011;
      step("rsw_decode", E_DECODE);
      step("rsw_memadr", E_MEMADR);
      mem_ready = 1'b0;
      step("rsw_memwr", E_MEMWR);
      rst = 1'b1;
      step("rsw_reset", ZERO);
      rst = 1'b0; mem_ready = 1'b1;
      step("rsw_fetch", E_FETCH_RDY);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
